// File: rtl/spi_ram_pkg.sv
// Shared SPI RAM link definitions: command codes, frame sizes and the master state encoding.
package spi_ram_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam int FRAME_BITS = 10;
  localparam int REPLY_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_SHIFT,
    ST_TURN,
    ST_READ,
    ST_END
  } state_t;

  // The leading mode bit tells the slave which half of the command set follows.
  function automatic logic frame_mode(input logic [1:0] cmd);
    return cmd[1];
  endfunction

endpackage

// File: rtl/spi_ram_master_if.sv
// Host command/response handshake plus the SPI pins of the RAM link.
interface spi_ram_master_if;
  import spi_ram_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_cmd;
  logic [REPLY_BITS-1:0] req_data;
  logic                  rsp_valid;
  logic [REPLY_BITS-1:0] rsp_data;
  logic                  busy;
  logic                  SS_n;
  logic                  MOSI;
  logic                  MISO;

  modport master (
    input  req_valid, req_cmd, req_data, MISO,
    output req_ready, rsp_valid, rsp_data, busy, SS_n, MOSI
  );

  modport slave (
    output req_valid, req_cmd, req_data, MISO,
    input  req_ready, rsp_valid, rsp_data, busy, SS_n, MOSI
  );

endinterface

// File: rtl/spi_ram_master.sv
// Frame-level SPI master for the single-port-RAM SPI slave; all outputs registered.
// Optional SPI_RAM_MASTER_STATS_EN adds frame_cnt / rd_cnt statistics outputs.
module spi_ram_master
  import spi_ram_pkg::*;
#(
  parameter int TURN_CYCLES = 2,
  parameter int GAP_CYCLES  = 1
) (
  input  logic             CLK,
  input  logic             rst,
`ifdef SPI_RAM_MASTER_STATS_EN
  output logic [15:0]      frame_cnt,
  output logic [15:0]      rd_cnt,
`endif
  spi_ram_master_if.master bus
);

  localparam logic [3:0] SHIFT_LOAD = 4'(FRAME_BITS - 1);
  localparam logic [3:0] TURN_LOAD  = 4'(TURN_CYCLES - 1);
  localparam logic [3:0] READ_LOAD  = 4'(REPLY_BITS - 1);
  localparam logic [3:0] GAP_LOAD   = 4'(GAP_CYCLES - 1);

  state_t                r_state, w_state_next;
  logic [3:0]            r_cnt, w_cnt_next;
  logic [FRAME_BITS-1:0] r_shift, w_shift_next;
  logic [REPLY_BITS-1:0] r_rx, w_rx_next;
  logic                  r_rd_frame, w_rd_frame_next;
  logic                  r_ss_n, w_ss_n_next;
  logic                  r_mosi, w_mosi_next;
  logic                  r_req_ready, w_req_ready_next;
  logic                  r_busy, w_busy_next;
  logic                  r_rsp_valid, w_rsp_valid_next;
  logic [REPLY_BITS-1:0] r_rsp_data, w_rsp_data_next;
  logic [REPLY_BITS-1:0] w_rx_shifted;
  logic                  w_accept;

  assign w_rx_shifted = {r_rx[REPLY_BITS-2:0], bus.MISO};
  assign w_accept     = bus.req_valid && r_req_ready && (r_state == ST_IDLE);

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_shift_next     = r_shift;
    w_rx_next        = r_rx;
    w_rd_frame_next  = r_rd_frame;
    w_rsp_data_next  = r_rsp_data;
    w_rsp_valid_next = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next    = ST_START;
          w_shift_next    = {bus.req_cmd, bus.req_data};
          w_rd_frame_next = (bus.req_cmd == CMD_RD_DATA);
          w_rx_next       = '0;
        end
      end
      ST_START: begin
        w_state_next = ST_SHIFT;
        w_cnt_next   = SHIFT_LOAD;
        w_shift_next = r_shift << 1;
      end
      ST_SHIFT: begin
        if (r_cnt == 4'd0) begin
          if (r_rd_frame) begin
            w_state_next = ST_TURN;
            w_cnt_next   = TURN_LOAD;
          end else begin
            w_state_next = ST_END;
            w_cnt_next   = GAP_LOAD;
          end
        end else begin
          w_cnt_next   = r_cnt - 4'd1;
          w_shift_next = r_shift << 1;
        end
      end
      ST_TURN: begin
        if (r_cnt == 4'd0) begin
          w_state_next = ST_READ;
          w_cnt_next   = READ_LOAD;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      ST_READ: begin
        // MISO is sampled on the edge that closes each READ cycle.
        w_rx_next = w_rx_shifted;
        if (r_cnt == 4'd0) begin
          w_state_next     = ST_END;
          w_cnt_next       = GAP_LOAD;
          w_rsp_data_next  = w_rx_shifted;
          w_rsp_valid_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      ST_END: begin
        if (r_cnt == 4'd0) begin
          w_state_next = ST_IDLE;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    // Pin values are a function of the state being entered, so they line up with it.
    w_ss_n_next      = 1'b1;
    w_mosi_next      = 1'b0;
    w_busy_next      = (w_state_next != ST_IDLE);
    w_req_ready_next = (w_state_next == ST_IDLE);
    unique case (w_state_next)
      ST_START: begin
        w_ss_n_next = 1'b0;
        w_mosi_next = frame_mode(bus.req_cmd);
      end
      ST_SHIFT: begin
        w_ss_n_next = 1'b0;
        w_mosi_next = r_shift[FRAME_BITS-1];
      end
      ST_TURN, ST_READ: begin
        w_ss_n_next = 1'b0;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_rx        <= '0;
      r_rd_frame  <= 1'b0;
      r_ss_n      <= 1'b1;
      r_mosi      <= 1'b0;
      r_req_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_shift     <= w_shift_next;
      r_rx        <= w_rx_next;
      r_rd_frame  <= w_rd_frame_next;
      r_ss_n      <= w_ss_n_next;
      r_mosi      <= w_mosi_next;
      r_req_ready <= w_req_ready_next;
      r_busy      <= w_busy_next;
      r_rsp_valid <= w_rsp_valid_next;
      r_rsp_data  <= w_rsp_data_next;
    end
  end

  assign bus.SS_n      = r_ss_n;
  assign bus.MOSI      = r_mosi;
  assign bus.req_ready = r_req_ready;
  assign bus.busy      = r_busy;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;

`ifdef SPI_RAM_MASTER_STATS_EN
  logic [15:0] r_frame_cnt;
  logic [15:0] r_rd_cnt;
  logic        w_end_entry;

  assign w_end_entry = (w_state_next == ST_END) && (r_state != ST_END);

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_frame_cnt <= '0;
      r_rd_cnt    <= '0;
    end else if (w_end_entry) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
      if (r_rd_frame) begin
        r_rd_cnt <= r_rd_cnt + 16'd1;
      end
    end
  end

  assign frame_cnt = r_frame_cnt;
  assign rd_cnt    = r_rd_cnt;
`endif

endmodule

// File: tb/tb_spi_ram_master.sv
// Scoreboard bench for spi_ram_master with a behavioural RAM slave on the SPI pins.
module tb_spi_ram_master;
  import spi_ram_pkg::*;

  localparam int TURN = 2;
  localparam int GAP  = 1;
  localparam int LEN_WR = 11;
  localparam int LEN_RD = 11 + TURN + 8;

  typedef struct {
    logic [10:0] bits;
    int          len;
  } frame_t;

  logic CLK = 1'b0;
  logic rst = 1'b1;
  always #5 CLK = ~CLK;

  spi_ram_master_if bus();

`ifdef SPI_RAM_MASTER_STATS_EN
  logic [15:0] frame_cnt;
  logic [15:0] rd_cnt;
`endif

  spi_ram_master #(.TURN_CYCLES(TURN), .GAP_CYCLES(GAP)) dut (
    .CLK      (CLK),
    .rst      (rst),
`ifdef SPI_RAM_MASTER_STATS_EN
    .frame_cnt(frame_cnt),
    .rd_cnt   (rd_cnt),
`endif
    .bus      (bus)
  );

  int tests = 0;
  int fails = 0;

  frame_t      frame_q[$];
  logic [7:0]  rsp_q[$];

  // Slave-model state
  logic [7:0]  mem [256];
  logic [7:0]  wr_addr = 8'h00;
  logic [7:0]  rd_addr = 8'h00;
  logic [10:0] rx_bits = '0;
  int          k = 0;
  bit          in_frame = 0;
  int          hi_run = 0;
  bit          b2b = 0;
  int          b2b_starts = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %0h", name, act);
    end
  endtask

  // RAM slave: decodes MOSI frames, answers read-data on MISO, scores each frame.
  always @(negedge CLK) begin
    frame_t f;
    if (bus.SS_n === 1'b0) begin
      if (!in_frame) begin
        if (b2b) begin
          if (b2b_starts > 0) check("b2b_gap", hi_run, GAP + 1);
          b2b_starts++;
        end
        in_frame = 1;
        k        = 0;
        rx_bits  = '0;
      end
      if (k < 11) rx_bits[10-k] = bus.MOSI;
      if (k >= 11 + TURN && k < 19 + TURN) bus.MISO = mem[rd_addr][18+TURN-k];
      else bus.MISO = 1'b0;
      k++;
      hi_run = 0;
    end else begin
      bus.MISO = 1'b0;
      if (in_frame) begin
        in_frame = 0;
        if (frame_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL frame_unexpected: got bits %b, required no frame", rx_bits);
        end else begin
          f = frame_q.pop_front();
          check("frame_bits", rx_bits, f.bits);
          check("frame_len", k, f.len);
        end
        if (k >= 11) begin
          case (rx_bits[9:8])
            CMD_WR_ADDR: wr_addr = rx_bits[7:0];
            CMD_WR_DATA: mem[wr_addr] = rx_bits[7:0];
            CMD_RD_ADDR: rd_addr = rx_bits[7:0];
            default: ;
          endcase
        end
      end
      hi_run++;
    end
  end

  // Response monitor
  always @(negedge CLK) begin
    logic [7:0] exp;
    if (bus.rsp_valid === 1'b1) begin
      if (rsp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rsp_unexpected: got rsp_data %0h, required no response", bus.rsp_data);
      end else begin
        exp = rsp_q.pop_front();
        check("rsp_data", bus.rsp_data, exp);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge CLK);
    while (bus.req_ready !== 1'b1 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: req_ready %b, required 1", bus.req_ready);
    end
  endtask

  // Presents a command and returns right after its accepting edge; req_valid stays high.
  task automatic issue(input logic [1:0] c, input logic [7:0] d, input int len);
    frame_t f;
    wait_ready();
    f.bits = {c[1], c, d};
    f.len  = len;
    frame_q.push_back(f);
    bus.req_valid = 1'b1;
    bus.req_cmd   = c;
    bus.req_data  = d;
    @(posedge CLK);
  endtask

  task automatic send(input logic [1:0] c, input logic [7:0] d);
    issue(c, d, (c == CMD_RD_DATA) ? LEN_RD : LEN_WR);
    @(negedge CLK);
    bus.req_valid = 1'b0;
  endtask

  task automatic reset_check();
    @(negedge CLK);
    rst = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_ss_n", bus.SS_n, 1);
    check("rst_mosi", bus.MOSI, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_data", bus.rsp_data, 8'h00);
    check("rst_ready_low", bus.req_ready, 0);
    rst = 1'b0;
    @(negedge CLK);
    check("rst_ready_high", bus.req_ready, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge CLK);
    while (bus.busy !== 1'b0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: busy %b, required 0", bus.busy);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v_mosi, v_ss, v_rdy, v_rsp;
    logic [1:0]  b_cmd [4];
    logic [7:0]  b_dat [4];

    bus.req_valid = 1'b0;
    bus.req_cmd   = 2'b00;
    bus.req_data  = 8'h00;

    reset_check();
    repeat (2) @(negedge CLK);

    // Write-addr 0xA5: exact pin timeline from the accepting edge.
    v_mosi = '0; v_ss = '0; v_rdy = '0;
    issue(CMD_WR_ADDR, 8'hA5, LEN_WR);
    for (int n = 1; n <= 13; n++) begin
      @(negedge CLK);
      if (n == 1) bus.req_valid = 1'b0;
      v_mosi[n] = bus.MOSI;
      v_ss[n]   = bus.SS_n;
      v_rdy[n]  = bus.req_ready;
    end
    check("wa_mosi_seq", v_mosi, 32'h0000_0A50);
    check("wa_ss_n_seq", v_ss, 32'h0000_3000);
    check("wa_ready_seq", v_rdy, 32'h0000_2000);

    // RAM loop through the slave model, timing the read-data frame.
    send(CMD_WR_ADDR, 8'h10);
    send(CMD_WR_DATA, 8'h3C);
    send(CMD_RD_ADDR, 8'h10);
    rsp_q.push_back(8'h3C);
    v_ss = '0; v_rdy = '0; v_rsp = '0;
    issue(CMD_RD_DATA, 8'h00, LEN_RD);
    for (int n = 1; n <= 24; n++) begin
      @(negedge CLK);
      if (n == 1) bus.req_valid = 1'b0;
      v_ss[n]  = bus.SS_n;
      v_rdy[n] = bus.req_ready;
      v_rsp[n] = bus.rsp_valid;
    end
    check("rd_rsp_valid_seq", v_rsp, 32'h0040_0000);
    check("rd_ready_seq", v_rdy, 32'h0180_0000);
    check("rd_ss_n_seq", v_ss, 32'h01C0_0000);
    check("rd_rsp_data_held", bus.rsp_data, 8'h3C);

    // Idle reset clears a non-zero held reply.
    reset_check();

    // Back-to-back with req_valid held high.
    b_cmd[0] = CMD_WR_ADDR; b_dat[0] = 8'h30;
    b_cmd[1] = CMD_WR_DATA; b_dat[1] = 8'h5A;
    b_cmd[2] = CMD_RD_ADDR; b_dat[2] = 8'h30;
    b_cmd[3] = CMD_RD_DATA; b_dat[3] = 8'h00;
    rsp_q.push_back(8'h5A);
    b2b = 1;
    for (int i = 0; i < 4; i++) begin
      issue(b_cmd[i], b_dat[i], (b_cmd[i] == CMD_RD_DATA) ? LEN_RD : LEN_WR);
    end
    @(negedge CLK);
    bus.req_valid = 1'b0;
    wait_idle();
    b2b = 0;
    check("b2b_frames", b2b_starts, 4);

    // Reset during READ bit 4: frame cut after 11+TURN+5 SS_n-low cycles.
    issue(CMD_RD_DATA, 8'h00, 11 + TURN + 5);
    for (int n = 1; n <= 18; n++) begin
      @(negedge CLK);
      if (n == 1) bus.req_valid = 1'b0;
    end
    rst = 1'b1;
    @(negedge CLK);
    check("abort_ss_n", bus.SS_n, 1);
    check("abort_mosi", bus.MOSI, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_rsp_valid", bus.rsp_valid, 0);
    check("abort_rsp_data", bus.rsp_data, 8'h00);
    rst = 1'b0;
    repeat (5) @(negedge CLK);

    rsp_q.push_back(8'h5A);
    send(CMD_RD_DATA, 8'h00);
    wait_idle();
    repeat (3) @(negedge CLK);

    check("frame_q_drained", frame_q.size(), 0);
    check("rsp_q_drained", rsp_q.size(), 0);
`ifdef SPI_RAM_MASTER_STATS_EN
    check("stats_frame_cnt", frame_cnt, 16'd1);
    check("stats_rd_cnt", rd_cnt, 16'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
